audio_sample_assembler: RTL and testbench
=========================================

AUDIO_SAMPLE_ASSEMBLER -- requirements
Module: audio_sample_assembler

Interface
REQ-001 SHALL provide parameter START_LEVEL, default 16: FIFO fill in bytes required before playback (re)starts.
REQ-002 SHALL provide parameter REQ_LEVEL, default 64: the host-request threshold in bytes.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, the SPDIF core clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port fifo_data_i, input, 8 bits: audio FIFO read data, valid the cycle after fifo_rdreq_o.
REQ-006 SHALL have port fifo_usedw_i, input, 8 bits: audio FIFO read-side fill level.
REQ-007 SHALL have port fifo_rdreq_o, output, 1 bit: audio FIFO read request, one byte per asserted cycle.
REQ-008 SHALL have port sample_req_i, input, 1 bit: one-cycle pulse from the SPDIF core requesting the next stereo frame.
REQ-009 SHALL have port sample_o, output, 48 bits: {right[23:0], left[23:0]} fed to the SPDIF core sample input.
REQ-010 SHALL have port host_req_o, output, 1 bit: request to the Raspberry Pi for more data.
REQ-011 SHALL have port underrun_cnt_o, output, 16 bits: saturating count of starved sample requests.

Function
REQ-012 SHALL implement states PRIME, RD, CAP and READY.
REQ-013 PRIME SHALL hold fifo_rdreq_o low and move to RD when fifo_usedw_i >= START_LEVEL.
REQ-014 RD SHALL assert fifo_rdreq_o for exactly one cycle and move to CAP, only if fifo_usedw_i != 0; otherwise it SHALL stay in RD with rdreq low.
REQ-015 CAP SHALL latch fifo_data_i into staging byte byte_idx, increment byte_idx, and return to RD, or go to READY when the frame is complete.
REQ-016 Byte order SHALL be little-endian: b0=L[7:0], b1=L[15:8], b2=R[7:0], b3=R[15:8].
REQ-017 Each 24-bit channel SHALL be {sample16, 8'h00}.
REQ-018 In READY, sample_req_i SHALL load the staged frame into sample_o on the next edge, clear byte_idx, and move to RD.
REQ-019 A sample_req_i pulse in any state other than READY SHALL be an underrun:
- sample_o <= 48'h0 (mute);
- underrun_cnt_o increments, saturating at 16'hFFFF;
- if fifo_usedw_i == 0, the state SHALL become PRIME, keeping byte_idx and the partial frame.
REQ-020 A sample_req_i pulse in the same cycle as the final CAP SHALL count as an underrun, and the completed frame SHALL wait in READY for the next request.
REQ-021 host_req_o SHALL be registered and equal (fifo_usedw_i < REQ_LEVEL), one cycle of latency.
REQ-022 fifo_rdreq_o SHALL never be asserted in two consecutive cycles.
REQ-023 fifo_rdreq_o SHALL never be asserted while fifo_usedw_i == 0.

Reset
REQ-024 rst_i SHALL, at the next clk_i edge, set:
- state = PRIME, byte_idx = 0, staging = 0;
- sample_o = 0, fifo_rdreq_o = 0, host_req_o = 0, underrun_cnt_o = 0.
REQ-025 Reset mid-frame SHALL discard partial bytes.
REQ-026 A rdreq issued in the reset cycle SHALL have its data ignored.

Configuration
REQ-027 Macro AUDIO_MONO_DUP_EN, when defined, SHALL make a frame 2 bytes (b0=low, b1=high) and duplicate that sample into both left and right.
REQ-028 Without AUDIO_MONO_DUP_EN, frames SHALL be 4 bytes interleaved stereo per REQ-016.

Verification
REQ-029 Scenario: FIFO at 15 bytes after reset -> no rdreq; raise to 16 -> rdreq pulses every second cycle.
REQ-030 Scenario: bytes 34,12,78,56 then sample_req_i -> sample_o = 48'h567800_123400.
REQ-031 Scenario: sample_req_i while in CAP with usedw=0 -> sample_o=0, underrun_cnt_o=1, state PRIME.
REQ-032 Scenario: 65536 forced underruns -> underrun_cnt_o holds at 16'hFFFF.
REQ-033 Scenario: usedw sweeps 63->64 -> host_req_o goes 1->0 one cycle later.
REQ-034 Scenario: AUDIO_MONO_DUP_EN defined, bytes CD,AB -> sample_o = 48'hABCD00_ABCD00.

Source files
------------

// File: rtl/audio_sample_assembler.sv
// Packs audio FIFO bytes into 48-bit SPDIF frames and mutes/counts sample requests that arrive before a frame is staged.
// AUDIO_MONO_DUP_EN: 2-byte mono frames copied to both channels; without it, 4-byte interleaved little-endian stereo.
module audio_sample_assembler #(
  parameter int START_LEVEL = 16,
  parameter int REQ_LEVEL   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  fifo_data_i,
  input  logic [7:0]  fifo_usedw_i,
  output logic        fifo_rdreq_o,
  input  logic        sample_req_i,
  output logic [47:0] sample_o,
  output logic        host_req_o,
  output logic [15:0] underrun_cnt_o
);

`ifdef AUDIO_MONO_DUP_EN
  localparam logic [1:0] LAST_IDX = 2'd1;
`else
  localparam logic [1:0] LAST_IDX = 2'd3;
`endif
  localparam logic [8:0] START_LVL = 9'(START_LEVEL);
  localparam logic [8:0] REQ_LVL   = 9'(REQ_LEVEL);

  typedef enum logic [1:0] {PRIME, RD, CAP, READY} state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [3:0][7:0] staging;
  logic [47:0]     frame;
  logic            fifo_empty;
  logic            frame_done;

  assign fifo_empty = (fifo_usedw_i == 8'd0);
  assign frame_done = (byte_idx == LAST_IDX);

  // Decoded from state so the FIFO data lands exactly in CAP and the request can never
  // outlive a fill level that has just dropped to zero.
  assign fifo_rdreq_o = (state == RD) && !fifo_empty;

`ifdef AUDIO_MONO_DUP_EN
  assign frame = {staging[1], staging[0], 8'h00, staging[1], staging[0], 8'h00};
`else
  assign frame = {staging[3], staging[2], 8'h00, staging[1], staging[0], 8'h00};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= PRIME;
      byte_idx       <= 2'd0;
      staging        <= '0;
      sample_o       <= '0;
      host_req_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      host_req_o <= ({1'b0, fifo_usedw_i} < REQ_LVL);

      case (state)
        PRIME: begin
          if ({1'b0, fifo_usedw_i} >= START_LVL) state <= RD;
        end
        RD: begin
          if (!fifo_empty) state <= CAP;
        end
        CAP: begin
          staging[byte_idx] <= fifo_data_i;
          if (frame_done) begin
            byte_idx <= 2'd0;
            state    <= READY;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            state    <= RD;
          end
        end
        READY: begin
          if (sample_req_i) begin
            sample_o <= frame;
            byte_idx <= 2'd0;
            state    <= RD;
          end
        end
        default: state <= PRIME;
      endcase

      // A completed frame is kept in READY even if the FIFO ran dry on its last byte.
      if (sample_req_i && state != READY) begin
        sample_o <= '0;
        if (underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
        if (fifo_empty && !(state == CAP && frame_done)) state <= PRIME;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_assembler.sv
// Bench: queue-based FIFO plus a byte-stream reference model of frame assembly, underruns and host requests.
module tb_audio_sample_assembler;

`ifdef AUDIO_MONO_DUP_EN
  localparam int FB = 2;
`else
  localparam int FB = 4;
`endif
  localparam int START = 16;
  localparam int REQ   = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  fifo_data_i = 8'h00;
  logic [7:0]  fifo_usedw_i = 8'h00;
  logic        fifo_rdreq_o;
  logic        sample_req_i = 1'b0;
  logic [47:0] sample_o;
  logic        host_req_o;
  logic [15:0] underrun_cnt_o;

  audio_sample_assembler #(.START_LEVEL(START), .REQ_LEVEL(REQ)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .fifo_data_i(fifo_data_i),
    .fifo_usedw_i(fifo_usedw_i),
    .fifo_rdreq_o(fifo_rdreq_o),
    .sample_req_i(sample_req_i),
    .sample_o(sample_o),
    .host_req_o(host_req_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // environment FIFO contents and reference model state
  logic [7:0]  q[$];
  logic [7:0]  avail[$];
  bit          pend_v;
  logic [7:0]  pend_b;
  bit          priming;
  bit          prev_rd;
  logic        last_rd;
  logic [47:0] exp_sample;
  logic [15:0] exp_cnt;
  logic        exp_host;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit req, input bit rst);
    logic       rd;
    logic       exp_rd;
    logic [7:0] popped;
    int         u;
    bit         was_priming;
    popped = 8'h00;
    fifo_usedw_i = (q.size() > 255) ? 8'd255 : 8'(q.size());
    sample_req_i = req;
    rst_i = rst;
    #1;
    rd = fifo_rdreq_o;
    if (!rst) begin
      exp_rd = !priming && (fifo_usedw_i != 0) && !prev_rd && (avail.size() + int'(pend_v) < FB);
      chk("rdreq", {47'd0, rd}, {47'd0, exp_rd});
    end
    last_rd = rd;
    @(posedge clk_i);
    u = int'(fifo_usedw_i);
    if (rd === 1'b1 && q.size() > 0) popped = q.pop_front();
    if (rst) begin
      avail.delete();
      pend_v = 0;
      priming = 1;
      exp_sample = '0;
      exp_cnt = '0;
      exp_host = 1'b0;
    end else begin
      exp_host = (u < REQ);
      was_priming = priming;
      if (was_priming && u >= START) priming = 0;
      if (req) begin
        if (avail.size() >= FB) begin
`ifdef AUDIO_MONO_DUP_EN
          exp_sample = {avail[1], avail[0], 8'h00, avail[1], avail[0], 8'h00};
`else
          exp_sample = {avail[3], avail[2], 8'h00, avail[1], avail[0], 8'h00};
`endif
          repeat (FB) void'(avail.pop_front());
        end else begin
          exp_sample = '0;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          if (u == 0 && !(pend_v && avail.size() + 1 == FB)) priming = 1;
        end
      end
      if (pend_v) avail.push_back(pend_b);
      pend_v = (rd === 1'b1);
      pend_b = popped;
    end
    prev_rd = rst ? 1'b0 : (rd === 1'b1);
    @(negedge clk_i);
    fifo_data_i = (rd === 1'b1) ? popped : 8'($urandom);
    chk("sample", sample_o, exp_sample);
    chk("underrun_cnt", {32'd0, underrun_cnt_o}, {32'd0, exp_cnt});
    chk("host_req", {47'd0, host_req_o}, {47'd0, exp_host});
    sample_req_i = 1'b0;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [47:0] first_frame;
    bit rich;

    // reset state
    tick(0, 1);
    tick(0, 1);
    chk("rst_sample", sample_o, 48'h0);
    chk("rst_cnt", {32'd0, underrun_cnt_o}, 48'h0);
    chk("rst_host", {47'd0, host_req_o}, 48'h0);
    chk("rst_rdreq", {47'd0, fifo_rdreq_o}, 48'h0);

    // 15 bytes: still priming
`ifdef AUDIO_MONO_DUP_EN
    q.push_back(8'hCD); q.push_back(8'hAB);
    first_frame = 48'hABCD00_ABCD00;
`else
    q.push_back(8'h34); q.push_back(8'h12); q.push_back(8'h78); q.push_back(8'h56);
    first_frame = 48'h567800_123400;
`endif
    while (q.size() < START - 1) q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      tick(0, 0);
      chk("prime_hold", {47'd0, last_rd}, 48'h0);
    end

    // 16th byte: one request every second cycle until the frame is staged
    q.push_back(8'($urandom));
    for (int i = 1; i <= 2 * FB + 2; i++) begin
      tick(0, 0);
      chk("rd_pattern", {47'd0, last_rd}, {47'd0, (i % 2 == 0) && (i <= 2 * FB)});
    end

    // host request threshold while the frame waits
    while (q.size() < REQ - 1) q.push_back(8'($urandom));
    tick(0, 0);
    chk("host_63", {47'd0, host_req_o}, 48'h1);
    q.push_back(8'($urandom));
    tick(0, 0);
    chk("host_64", {47'd0, host_req_o}, 48'h0);

    // frame delivery, then underrun while capturing with an empty FIFO
    q.delete();
    q.push_back(8'($urandom));
    tick(1, 0);
    chk("first_frame", sample_o, first_frame);
    tick(0, 0);
    chk("rd_last_byte", {47'd0, last_rd}, 48'h1);
    tick(1, 0);
    chk("cap_underrun_mute", sample_o, 48'h0);
    chk("cap_underrun_cnt", {32'd0, underrun_cnt_o}, 48'h1);
    for (int i = 0; i < START - 1; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      tick(0, 0);
      chk("reprime_hold", {47'd0, last_rd}, 48'h0);
    end
    q.push_back(8'($urandom));

    // randomized traffic: rich and starved phases, occasional resets
    for (int n = 0; n < 3000; n++) begin
      rich = ((n / 400) % 2) == 0;
      if (q.size() < 200 && $urandom_range(9) < (rich ? 7 : 1)) q.push_back(8'($urandom));
      tick($urandom_range(9) == 0, $urandom_range(999) == 0);
    end

    // reset mid-frame discards partial bytes
    for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
    tick(1, 1);
    repeat (5) tick(0, 0);
    tick(0, 1);
    chk("midrst_cnt", {32'd0, underrun_cnt_o}, 48'h0);
    for (int i = 0; i < 40; i++) tick((i % 12) == 11, 0);

    // counter saturation
    q.delete();
    for (int i = 0; i < 65540; i++) tick(1, 0);
    chk("underrun_sat", {32'd0, underrun_cnt_o}, 48'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
